ir_beat_loader: RTL and testbench

- Parametrised instruction register assembled from NBEATS narrow memory beats of BEAT_W bits into a WORD_W = BEAT_W*NBEATS register.
- Successor to the fixed 16-bit two-half IR: the beat counter and slice steering are internal, so no external half-select is needed.
- Sits between the memory data bus and the control unit. Holds the standard funsel register operations and adds a valid/ready beat handshake and an instruction-valid flag.

---
 rtl/ir_beat_loader.sv | 106 ++++++++++
 tb/tb_ir_beat_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ir_beat_loader.sv
// Instruction register filled from NBEATS memory beats over a valid/ready handshake,
// with funsel dec/inc/load/clear. Define IR_LOW_FIRST_EN for low-slice-first beat order.
module ir_beat_loader #(
    parameter int  BEAT_W = 8,
    parameter int  NBEATS = 2,
    localparam int WORD_W = BEAT_W * NBEATS,
    localparam int IDX_W  = $clog2(NBEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic [1:0]        funsel,
    input  logic [BEAT_W-1:0] beat_in,
    input  logic              beat_valid,
    output logic              beat_ready,
    output logic [WORD_W-1:0] ir_out,
    output logic              ir_valid,
    output logic              busy,
    output logic [IDX_W-1:0]  beat_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_DEC  = 2'b00,
        OP_INC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    state_t state;
    op_t    op;
    logic   xfer;
    logic   last_beat;

    assign op         = op_t'(funsel);
    assign beat_ready = (state == FILL);
    assign busy       = (state == FILL);
    assign xfer       = beat_valid && beat_ready;
    assign last_beat  = (beat_idx == IDX_W'(NBEATS - 1));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values and the block order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ir_out   <= '0;
            ir_valid <= 1'b0;
            beat_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (e) begin
                        case (op)
                            OP_LOAD: begin
                                state    <= FILL;
                                beat_idx <= '0;
                                ir_valid <= 1'b0;
                            end
                            OP_CLR: begin
                                state    <= IDLE;
                                ir_out   <= '0;
                                ir_valid <= 1'b0;
                            end
                            OP_INC:  ir_out <= ir_out + WORD_W'(1);
                            default: ir_out <= ir_out - WORD_W'(1);
                        endcase
                    end
                end

                FILL: begin
                    // Clear aborts the fill and wins over a beat offered in the same cycle.
                    if (e && op == OP_CLR) begin
                        state    <= IDLE;
                        ir_out   <= '0;
                        ir_valid <= 1'b0;
                        beat_idx <= '0;
                    end else if (xfer) begin
                        for (int k = 0; k < NBEATS; k++) begin
`ifdef IR_LOW_FIRST_EN
                            if (beat_idx == IDX_W'(k))
`else
                            if (beat_idx == IDX_W'(NBEATS - 1 - k))
`endif
                                ir_out[k*BEAT_W +: BEAT_W] <= beat_in;
                        end
                        if (last_beat) begin
                            state    <= DONE;
                            ir_valid <= 1'b1;
                            beat_idx <= '0;
                        end else begin
                            beat_idx <= beat_idx + IDX_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_beat_loader.sv
// Directed bench for ir_beat_loader: an 8x2 instance for fill/arith/refill and a
// 4x4 instance for mid-fill abort. Expected words follow the IR_LOW_FIRST_EN build.
module tb_ir_beat_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit beats, 2 per word
    logic        e, beat_valid;
    logic [1:0]  funsel;
    logic [7:0]  beat_in;
    logic        beat_ready, ir_valid, busy;
    logic [15:0] ir_out;
    logic [0:0]  beat_idx;

    // 4-bit beats, 4 per word
    logic        d4_e, d4_beat_valid;
    logic [1:0]  d4_funsel;
    logic [3:0]  d4_beat_in;
    logic        d4_beat_ready, d4_ir_valid, d4_busy;
    logic [15:0] d4_ir_out;
    logic [1:0]  d4_beat_idx;

    int checks = 0;
    int errors = 0;

`ifdef IR_LOW_FIRST_EN
    localparam logic [15:0] EXP_AB_PART = 16'h00AB;
    localparam logic [15:0] EXP_ABCD    = 16'hCDAB;
    localparam logic [15:0] EXP_5A_PART = 16'h005A;
    localparam logic [15:0] EXP_5AC3    = 16'hC35A;
    localparam logic [15:0] EXP_12_PART = 16'hCD12;
    localparam logic [15:0] EXP_1234    = 16'h3412;
    localparam logic [15:0] EXP4_PART   = 16'h0021;
`else
    localparam logic [15:0] EXP_AB_PART = 16'hAB00;
    localparam logic [15:0] EXP_ABCD    = 16'hABCD;
    localparam logic [15:0] EXP_5A_PART = 16'h5A00;
    localparam logic [15:0] EXP_5AC3    = 16'h5AC3;
    localparam logic [15:0] EXP_12_PART = 16'h12CD;
    localparam logic [15:0] EXP_1234    = 16'h1234;
    localparam logic [15:0] EXP4_PART   = 16'h1200;
`endif

    ir_beat_loader #(.BEAT_W(8), .NBEATS(2)) dut (
        .clk(clk), .rst(rst), .e(e), .funsel(funsel), .beat_in(beat_in),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .ir_out(ir_out),
        .ir_valid(ir_valid), .busy(busy), .beat_idx(beat_idx)
    );

    ir_beat_loader #(.BEAT_W(4), .NBEATS(4)) dut4 (
        .clk(clk), .rst(rst), .e(d4_e), .funsel(d4_funsel), .beat_in(d4_beat_in),
        .beat_valid(d4_beat_valid), .beat_ready(d4_beat_ready), .ir_out(d4_ir_out),
        .ir_valid(d4_ir_valid), .busy(d4_busy), .beat_idx(d4_beat_idx)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] f);
        e = 1'b1; funsel = f;
        tick();
        e = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        beat_valid = 1'b1; beat_in = b;
        tick();
        beat_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        e = 1'b1; funsel = 2'b10; beat_valid = 1'b1; beat_in = 8'h55;
        d4_e = 1'b1; d4_funsel = 2'b10; d4_beat_valid = 1'b1; d4_beat_in = 4'h5;
        tick(2);
        checks++; if (ir_out !== 16'h0000) begin errors++; $display("FAIL reset_ir_out: got %h expected 0000", ir_out); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b expected 0", ir_valid); end
        checks++; if (beat_ready !== 1'b0) begin errors++; $display("FAIL reset_beat_ready: got %b expected 0", beat_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (beat_idx !== 1'b0) begin errors++; $display("FAIL reset_beat_idx: got %0d expected 0", beat_idx); end
        checks++; if (d4_ir_out !== 16'h0000 || d4_busy !== 1'b0) begin errors++; $display("FAIL reset_d4: got ir_out %h busy %b expected 0000 0", d4_ir_out, d4_busy); end
        rst = 1'b0;
        e = 1'b0; funsel = 2'b00; beat_valid = 1'b0; beat_in = '0;
        d4_e = 1'b0; d4_funsel = 2'b00; d4_beat_valid = 1'b0; d4_beat_in = '0;
        tick();
        checks++; if (busy !== 1'b0 || ir_out !== 16'h0000) begin errors++; $display("FAIL post_reset_idle: got busy %b ir_out %h expected 0 0000", busy, ir_out); end
    endtask

    task automatic test_two_beat_fill;
        cmd(2'b10);
        checks++; if (busy !== 1'b1 || beat_ready !== 1'b1) begin errors++; $display("FAIL fill_entered: got busy %b ready %b expected 1 1", busy, beat_ready); end
        send(8'hAB);
        checks++; if (ir_out !== EXP_AB_PART) begin errors++; $display("FAIL fill_first_slice: got %h expected %h", ir_out, EXP_AB_PART); end
        checks++; if (beat_idx !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("FAIL fill_after_first: got idx %0d valid %b expected 1 0", beat_idx, ir_valid); end
        tick(3);
        checks++; if (beat_idx !== 1'b1 || busy !== 1'b1 || ir_out !== EXP_AB_PART) begin errors++; $display("FAIL fill_stall: got idx %0d busy %b ir_out %h expected 1 1 %h", beat_idx, busy, ir_out, EXP_AB_PART); end
        send(8'hCD);
        checks++; if (ir_out !== EXP_ABCD) begin errors++; $display("FAIL fill_word: got %h expected %h", ir_out, EXP_ABCD); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fill_ir_valid: got %b expected 1", ir_valid); end
        checks++; if (beat_ready !== 1'b0 || busy !== 1'b0 || beat_idx !== 1'b0) begin errors++; $display("FAIL fill_done_flags: got ready %b busy %b idx %0d expected 0 0 0", beat_ready, busy, beat_idx); end
        send(8'hEE);
        checks++; if (ir_out !== EXP_ABCD || ir_valid !== 1'b1) begin errors++; $display("FAIL done_ignores_beat: got %h valid %b expected %h 1", ir_out, ir_valid, EXP_ABCD); end
    endtask

    task automatic test_inc_dec;
        cmd(2'b10);
        send(8'hFF);
        send(8'hFF);
        checks++; if (ir_out !== 16'hFFFF || ir_valid !== 1'b1) begin errors++; $display("FAIL arith_setup: got %h valid %b expected ffff 1", ir_out, ir_valid); end
        cmd(2'b01);
        checks++; if (ir_out !== 16'h0000 || ir_valid !== 1'b1) begin errors++; $display("FAIL inc_wrap: got %h valid %b expected 0000 1", ir_out, ir_valid); end
        cmd(2'b00);
        checks++; if (ir_out !== 16'hFFFF || ir_valid !== 1'b1) begin errors++; $display("FAIL dec_wrap: got %h valid %b expected ffff 1", ir_out, ir_valid); end
        funsel = 2'b01; tick(2);
        checks++; if (ir_out !== 16'hFFFF) begin errors++; $display("FAIL e0_hold: got %h expected ffff", ir_out); end
        cmd(2'b00);
        checks++; if (ir_out !== 16'hFFFE) begin errors++; $display("FAIL dec_plain: got %h expected fffe", ir_out); end
        cmd(2'b11);
        checks++; if (ir_out !== 16'h0000 || ir_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear: got %h valid %b busy %b expected 0000 0 0", ir_out, ir_valid, busy); end
        cmd(2'b01);
        checks++; if (ir_out !== 16'h0001 || ir_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inc_idle: got %h valid %b busy %b expected 0001 0 0", ir_out, ir_valid, busy); end
    endtask

    task automatic test_abort;
        d4_e = 1'b1; d4_funsel = 2'b10; tick(); d4_e = 1'b0;
        d4_beat_valid = 1'b1; d4_beat_in = 4'h1; tick();
        d4_beat_in = 4'h2; tick();
        d4_beat_valid = 1'b0;
        checks++; if (d4_ir_out !== EXP4_PART || d4_beat_idx !== 2'd2) begin errors++; $display("FAIL abort_partial: got %h idx %0d expected %h 2", d4_ir_out, d4_beat_idx, EXP4_PART); end
        d4_e = 1'b1; d4_funsel = 2'b11; d4_beat_valid = 1'b1; d4_beat_in = 4'h3;
        tick();
        d4_e = 1'b0;
        checks++; if (d4_ir_out !== 16'h0000 || d4_ir_valid !== 1'b0) begin errors++; $display("FAIL abort_clear: got %h valid %b expected 0000 0", d4_ir_out, d4_ir_valid); end
        checks++; if (d4_busy !== 1'b0 || d4_beat_ready !== 1'b0 || d4_beat_idx !== 2'd0) begin errors++; $display("FAIL abort_idle: got busy %b ready %b idx %0d expected 0 0 0", d4_busy, d4_beat_ready, d4_beat_idx); end
        tick();
        d4_beat_valid = 1'b0;
        checks++; if (d4_ir_out !== 16'h0000) begin errors++; $display("FAIL abort_beat_dropped: got %h expected 0000", d4_ir_out); end
    endtask

    task automatic test_ignored_ops;
        cmd(2'b11);
        cmd(2'b10);
        send(8'h5A);
        cmd(2'b01);
        checks++; if (ir_out !== EXP_5A_PART || beat_idx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fill_ignore_inc: got %h idx %0d busy %b expected %h 1 1", ir_out, beat_idx, busy, EXP_5A_PART); end
        cmd(2'b10);
        checks++; if (ir_out !== EXP_5A_PART || beat_idx !== 1'b1) begin errors++; $display("FAIL fill_ignore_load: got %h idx %0d expected %h 1", ir_out, beat_idx, EXP_5A_PART); end
        e = 1'b1; funsel = 2'b00;
        send(8'hC3);
        e = 1'b0;
        checks++; if (ir_out !== EXP_5AC3 || ir_valid !== 1'b1) begin errors++; $display("FAIL fill_ignore_dec_complete: got %h valid %b expected %h 1", ir_out, ir_valid, EXP_5AC3); end
    endtask

    task automatic test_refill;
        cmd(2'b10);
        send(8'hAB);
        send(8'hCD);
        checks++; if (ir_out !== EXP_ABCD || ir_valid !== 1'b1) begin errors++; $display("FAIL refill_first: got %h valid %b expected %h 1", ir_out, ir_valid, EXP_ABCD); end
        cmd(2'b10);
        checks++; if (ir_valid !== 1'b0 || busy !== 1'b1 || ir_out !== EXP_ABCD) begin errors++; $display("FAIL refill_start: got valid %b busy %b ir_out %h expected 0 1 %h", ir_valid, busy, ir_out, EXP_ABCD); end
        send(8'h12);
        checks++; if (ir_valid !== 1'b0 || ir_out !== EXP_12_PART) begin errors++; $display("FAIL refill_mid: got valid %b ir_out %h expected 0 %h", ir_valid, ir_out, EXP_12_PART); end
        send(8'h34);
        checks++; if (ir_out !== EXP_1234 || ir_valid !== 1'b1) begin errors++; $display("FAIL refill_word: got %h valid %b expected %h 1", ir_out, ir_valid, EXP_1234); end
    endtask

    initial begin
        test_reset();
        test_two_beat_fill();
        test_inc_dec();
        test_abort();
        test_ignored_ops();
        test_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
